// File: rtl/pio_pulse_pkg.sv
// Shared definitions for the pulse-capable output PIO: register addresses,
// pulse engine state encoding and counter width.
package pio_pulse_pkg;

  localparam int PLEN_W = 16;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_SET      = 3'd1;
  localparam logic [2:0] ADDR_CLEAR    = 3'd2;
  localparam logic [2:0] ADDR_PLEN     = 3'd3;
  localparam logic [2:0] ADDR_PULSE    = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/pulse_timer.sv
// One-shot pulse timer: holds ACTIVE for max(len,1) clocks after start and
// flags the last active cycle with done_pulse.
module pulse_timer
  import pio_pulse_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PLEN_W-1:0] len,
  output logic              active,
  output logic              done_pulse
);

  pulse_state_t      state, state_next;
  logic [PLEN_W-1:0] cnt, cnt_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = ACTIVE;
          // A zero length still produces a single-cycle pulse.
          cnt_next   = (len == '0) ? '0 : len - PLEN_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - PLEN_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  assign active     = (state == ACTIVE);
  assign done_pulse = active && (cnt == '0);

endmodule

// File: rtl/pio_pulse_out.sv
// Avalon-MM output PIO with atomic set/clear, a timed bit-inverting pulse
// engine and a maskable completion interrupt.
module pio_pulse_out
  import pio_pulse_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  pmask;
  logic [PLEN_W-1:0] plen;
  logic              irq_mask;
  logic              done;
  logic              active;
  logic              done_pulse;
  logic              start;
  logic              wr;
  logic [WIDTH-1:0]  wd;
  logic [31:0]       rd_next;

  // Upper writedata bits are meaningless for narrow configurations.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr = chipselect && !write_n;
  assign wd = writedata[WIDTH-1:0];

  // A zero mask or a write during a running pulse never reaches the timer,
  // so pmask stays stable for the whole pulse.
  assign start = wr && (address == ADDR_PULSE) && (wd != '0) && !active;

  pulse_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .len        (plen),
    .active     (active),
    .done_pulse (done_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= RESET_VALUE;
      pmask    <= '0;
      plen     <= '0;
      irq_mask <= 1'b0;
      done     <= 1'b0;
      readdata <= '0;
    end else begin
      readdata <= rd_next;
      if (wr) begin
        case (address)
          ADDR_DATA:     data     <= wd;
          ADDR_SET:      data     <= data | wd;
          ADDR_CLEAR:    data     <= data & ~wd;
          ADDR_PLEN:     plen     <= writedata[PLEN_W-1:0];
          ADDR_IRQ_MASK: irq_mask <= writedata[0];
          default: ;
        endcase
      end
      if (start) pmask <= wd;
      // Completion takes priority over a simultaneous acknowledge.
      if (done_pulse)                          done <= 1'b1;
      else if (wr && address == ADDR_STATUS)   done <= 1'b0;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next = 32'(data);
      ADDR_PLEN:     rd_next = 32'(plen);
      ADDR_PULSE:    rd_next = 32'(active);
      ADDR_IRQ_MASK: rd_next = 32'(irq_mask);
      ADDR_STATUS:   rd_next = 32'(done);
      default: ;
    endcase
  end

  assign irq      = done & irq_mask;
  assign out_port = data ^ (active ? pmask : '0);

endmodule

// File: tb/tb_pio_pulse_out.sv
// Self-checking bench for pio_pulse_out: directed scenarios plus random bus
// traffic, compared every cycle against a time-window reference model.
module tb_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd7;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  out_port;

  int checks = 0;
  int failures = 0;

  pio_pulse_out #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Reference model: a pulse is a window of edge numbers [start, start+L).
  logic [7:0]  m_data = 8'hA5;
  logic [7:0]  m_pmask = '0;
  logic [15:0] m_plen = '0;
  logic        m_mask = 1'b0;
  logic        m_done = 1'b0;
  logic        m_on = 1'b0;
  int          m_pend = 0;
  int          edge_n = 0;
  logic [31:0] m_rd = '0;
  logic        m_busy_prev;
  logic        m_done_set;
  logic        m_wr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  = 8'hA5;
      m_pmask = '0;
      m_plen  = '0;
      m_mask  = 1'b0;
      m_done  = 1'b0;
      m_on    = 1'b0;
      m_pend  = 0;
      m_rd    = '0;
    end else begin
      edge_n      = edge_n + 1;
      m_busy_prev = m_on && (edge_n - 1 < m_pend);
      m_done_set  = m_on && (edge_n == m_pend);
      m_wr        = chipselect && !write_n;
      case (address)
        3'd0:    m_rd = {24'b0, m_data};
        3'd3:    m_rd = {16'b0, m_plen};
        3'd4:    m_rd = {31'b0, m_busy_prev};
        3'd5:    m_rd = {31'b0, m_mask};
        3'd6:    m_rd = {31'b0, m_done};
        default: m_rd = '0;
      endcase
      if (m_wr) begin
        case (address)
          3'd0: m_data = writedata[7:0];
          3'd1: m_data = m_data | writedata[7:0];
          3'd2: m_data = m_data & ~writedata[7:0];
          3'd3: m_plen = writedata[15:0];
          3'd4: if (!m_busy_prev && writedata[7:0] != 8'd0) begin
                  m_on    = 1'b1;
                  m_pend  = edge_n + ((m_plen == 16'd0) ? 1 : int'(m_plen));
                  m_pmask = writedata[7:0];
                end
          3'd5: m_mask = writedata[0];
          3'd6: m_done = 1'b0;
          default: ;
        endcase
      end
      if (m_done_set) m_done = 1'b1;
    end
  end

  function automatic logic [7:0] exp_out();
    return m_data ^ ((m_on && edge_n < m_pend) ? m_pmask : 8'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("out_port", 32'(out_port), 32'(exp_out()));
    check("irq", 32'(irq), 32'(m_done & m_mask));
    check("readdata", readdata, m_rd);
  endtask

  // Compare at the falling edge, then drive the next bus cycle.
  task automatic step(input logic [2:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    compare();
    address    = a;
    chipselect = w;
    write_n    = !w;
    writedata  = d;
  endtask

  task automatic idle();
    step(3'd7, 1'b0, 32'd0);
  endtask

  initial begin
    int cnt;

    // Reset state
    idle();
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    check("rst_out", 32'(out_port), 32'hA5);
    check("rst_rd", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // DATA write and readback
    step(3'd0, 1'b1, 32'h3C);
    step(3'd0, 1'b0, 32'h0);
    check("data_out", 32'(out_port), 32'h3C);
    idle();
    check("data_rd", readdata, 32'h3C);

    // SET / CLEAR
    step(3'd0, 1'b1, 32'h0F);
    step(3'd1, 1'b1, 32'hF0);
    step(3'd2, 1'b1, 32'h81);
    check("set_out", 32'(out_port), 32'hFF);
    step(3'd1, 1'b0, 32'h0);
    check("clr_out", 32'(out_port), 32'h7E);
    step(3'd2, 1'b0, 32'h0);
    check("set_rd", readdata, 32'h0);
    idle();
    check("clr_rd", readdata, 32'h0);

    // 5-cycle pulse with interrupt
    step(3'd0, 1'b1, 32'h00);
    step(3'd3, 1'b1, 32'd5);
    step(3'd5, 1'b1, 32'd1);
    step(3'd4, 1'b1, 32'h01);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (out_port == 8'h01) cnt++;
      if (i == 4) check("irq_before_end", 32'(irq), 32'h0);
      if (i == 5) check("irq_at_end", 32'(irq), 32'h1);
    end
    check("pulse5_len", 32'(cnt), 32'd5);
    step(3'd6, 1'b1, 32'h0);
    idle();
    check("irq_cleared", 32'(irq), 32'h0);

    // PLEN=0 gives a single-cycle pulse
    step(3'd3, 1'b1, 32'd0);
    step(3'd4, 1'b1, 32'h01);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (out_port == 8'h01) cnt++;
    end
    check("pulse0_len", 32'(cnt), 32'd1);
    step(3'd6, 1'b1, 32'h0);

    // PULSE write while active is ignored
    step(3'd3, 1'b1, 32'd10);
    step(3'd4, 1'b1, 32'h01);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2)      step(3'd4, 1'b1, 32'h02);
      else if (i == 4) step(3'd4, 1'b0, 32'h0);
      else             idle();
      if (out_port == 8'h01) cnt++;
      if (i == 5) check("busy_rd", readdata, 32'h1);
    end
    check("pulse10_len", 32'(cnt), 32'd10);
    step(3'd6, 1'b1, 32'h0);

    // DATA write mid-pulse, STATUS write coinciding with completion
    step(3'd3, 1'b1, 32'd8);
    step(3'd4, 1'b1, 32'h01);
    for (int i = 0; i < 12; i++) begin
      if (i == 3)      step(3'd0, 1'b1, 32'h10);
      else if (i == 7) step(3'd6, 1'b1, 32'h0);
      else if (i == 8) step(3'd6, 1'b0, 32'h0);
      else             idle();
      if (i == 4) check("mid_data_out", 32'(out_port), 32'h11);
      if (i == 9) begin
        check("post_data_out", 32'(out_port), 32'h10);
        check("done_set_wins", readdata, 32'h1);
      end
    end
    step(3'd6, 1'b1, 32'h0);

    // Asynchronous reset mid-pulse
    step(3'd3, 1'b1, 32'd10);
    step(3'd4, 1'b1, 32'h0F);
    idle();
    idle();
    idle();
    #2 reset_n = 1'b0;
    #1 check("rst_async_out", 32'(out_port), 32'hA5);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    step(3'd4, 1'b0, 32'h0);
    step(3'd6, 1'b0, 32'h0);
    check("rst_busy", readdata, 32'h0);
    idle();
    check("rst_done", readdata, 32'h0);
    check("rst_irq2", 32'(irq), 32'h0);

    // Random bus traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd3) ? 32'($urandom_range(0, 12)) : $urandom;
      @(negedge clk);
      compare();
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        #1 check("rnd_rst_out", 32'(out_port), 32'hA5);
        @(negedge clk);
        reset_n = 1'b1;
      end
      address    = a;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = d;
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_pulse_out.md
# pio_pulse_out

Avalon-MM slave output PIO for the Cyclone III kit designs: drives a `WIDTH`-bit `out_port` from a CPU-writable data register. It adds atomic set and clear, plus a timed one-shot pulse engine that inverts selected bits for a programmed number of clocks and then restores them. Completion is reported through a maskable level interrupt. It is the output-direction counterpart of the edge-capture input PIOs on the same Nios II system bus.

## Interface
Parameters:
- `WIDTH`, 8, width of `out_port`, data and pulse mask registers (1..32)
- `RESET_VALUE`, 0, value of the data register after reset

Ports:
- `clk` in 1: system clock; the only clock in the block
- `reset_n` in 1: reset, asynchronous and active-low; every register clears to its reset value
- `address` in 3: word register index
- `chipselect` in 1: slave select
- `write_n` in 1: active-low write strobe; a write occurs when `chipselect && !write_n`
- `writedata` in 32: write data
- `readdata` out 32: registered read data, read latency 1; reset value 0
- `irq` out 1: `done & irq_mask`; reset value 0
- `out_port` out `WIDTH`: `data ^ (active ? pmask : 0)`, derived from registers only; reset value `RESET_VALUE`

## Operation
Register map (by address; unused read bits are 0):
- 0 DATA, R/W: `data <= writedata[WIDTH-1:0]`
- 1 SET, W: `data <= data | writedata`; reads return 0
- 2 CLEAR, W: `data <= data & ~writedata`; reads return 0
- 3 PLEN, R/W: 16-bit pulse length L; reset value 0; L = 0 is treated as 1
- 4 PULSE, W: start a pulse with `pmask <= writedata[WIDTH-1:0]`; read returns bit0 = busy (state ACTIVE)
- 5 IRQ_MASK, R/W: bit0 only
- 6 STATUS: read returns bit0 = `done`; any write clears `done`
- 7: reserved; reads return 0, writes are ignored

State machine:
- IDLE: a PULSE write with a nonzero mask moves the block to ACTIVE and loads `cnt <= max(L,1)-1`. A PULSE write with mask 0 is ignored.
- ACTIVE: if `cnt == 0`, return to IDLE and set `done`; otherwise decrement `cnt`. A PULSE write while ACTIVE is ignored: no restart and no mask change.

Rules:
- DATA, SET and CLEAR writes are legal while ACTIVE. They update `data` immediately, and the output tracks `data ^ pmask`. On return to IDLE the output equals the current `data`, so no separate restore register is needed.
- If `done` is set and a STATUS write lands in the same cycle, set wins and `done` stays 1.
- A PLEN write while ACTIVE does not affect the running pulse; it applies to the next one.
- `readdata` is loaded every clock from the read mux addressed by `address`, regardless of `chipselect`.
- Reset asserted mid-pulse: state returns to IDLE, `cnt`, `pmask` and `done` clear, and `out_port` returns to `RESET_VALUE` asynchronously.

## Timing
- A write sampled at clock edge N updates its register at edge N; `out_port` reflects the change immediately after edge N.
- Pulse: a PULSE write at edge N inverts `out_port` bits from after edge N until edge N+L, i.e. exactly L cycles (1 cycle for L=0). `done` and `irq` (if masked in) rise after edge N+L.
- Back-to-back pulses: the earliest accepted restart is a PULSE write at edge N+L+1, which gives one cycle at the base value between pulses.
- Read: `address` sampled at edge N returns its data on `readdata` after edge N.
- `cnt` is 16 bits with no wrap; the maximum pulse is 65535 cycles.

## Structure
- Shared package `pio_pulse_pkg` holds:
  - address constants `ADDR_DATA` .. `ADDR_STATUS`
  - the state enum `{IDLE, ACTIVE}`
  - `PLEN_W = 16`
- One sub-module, `pulse_timer`, contains the state machine and down-counter. Its ports are `clk`, `reset_n`, `start`, `len[15:0]`, `active`, and a one-cycle `done_pulse`. The top level owns the register file, read mux, `done` capture and `irq`.

## Test plan
- Reset with `RESET_VALUE=8'hA5`: `out_port=8'hA5`, `readdata=0`, `irq=0`. Write DATA `8'h3C`: `out_port=8'h3C` the next cycle; reading address 0 returns `32'h3C`.
- Starting from DATA `8'h0F`: SET `8'hF0` gives `8'hFF`; then CLEAR `8'h81` gives `8'h7E`. Reads of addresses 1 and 2 return 0.
- PLEN=5, IRQ_MASK=1, PULSE `8'h01` with DATA `8'h00`: `out_port=8'h01` for exactly 5 cycles, then `8'h00`. `irq` rises in the same cycle the output restores; a STATUS write drops `irq` the next cycle.
- PLEN=0, then PULSE: a 1-cycle pulse. A PULSE write while ACTIVE (PLEN=10, second write at cycle 3): no extension, the pulse ends at cycle 10, and busy reads 1 mid-pulse.
- During a PLEN=8 pulse with mask `8'h01` on DATA `8'h00`, write DATA `8'h10` at cycle 4: `out_port=8'h11`, then `8'h10` after the end. If `done` sets in the same cycle as a STATUS write, `done` stays 1.
- Assert `reset_n` low at cycle 3 of a pulse: `out_port` returns to `RESET_VALUE` without a clock edge. After release, busy=0, `done=0`, `irq=0`.
